// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Output buffer depth; two entries let one word sit in the output
  // register while the next read lands, sustaining 1 word/cycle.
  localparam int FETCH_BUF_DEPTH = 2;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Purpose: 2-entry FIFO with registered head, push/pop/flush and occupancy count.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: none internally; the caller must never push into a full FIFO
//               (the top-level credit check guarantees this).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push, din    write strobe and data
//   pop          head consumed this cycle (only legal when count != 0)
//   flush        discard all entries at the next edge (beats push/pop)
//   dout         head entry, stable until popped
//   count        occupancy 0..2
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;

  assign dout = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the head either takes the new word
          // directly or advances to the old tail.
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // Depth is fixed at two by the head/tail structure above.
  logic unused_depth;
  assign unused_depth = (FETCH_BUF_DEPTH == 2);

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: instruction-fetch sequencer between PC, synchronous program memory and decoder.
// Latency: 2 cycles from read issue to ins_valid (memory read + output buffer register).
// Backpressure: issue is credit-limited by the 2-entry output buffer; ins_ready low
//               stalls pc_inc with at most two words parked, nothing lost.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       leave IDLE and fetch from the current PC
//   pc_val, pc_max_reached      PC value and registered wrap flag
//   pc_inc, pc_overwrite,
//   pc_new_val                  PC increment / load controls
//   imem_en, imem_addr,
//   imem_rdata                  program-memory read port (data 1 cycle after en)
//   ins_valid, ins_ready,
//   ins_data, ins_addr          decoder word handshake
//   jmp_req, jmp_addr           decoder jump request (single-cycle pulse)
//   halted                      HALT reached and nothing left to deliver
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int INSTR_W      = 8,
  parameter bit HALT_ON_WRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_val,
  input  logic               pc_max_reached,
  output logic               pc_inc,
  output logic               pc_overwrite,
  output logic [ADDR_W-1:0]  pc_new_val,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ins_valid,
  input  logic               ins_ready,
  output logic [INSTR_W-1:0] ins_data,
  output logic [ADDR_W-1:0]  ins_addr,
  input  logic               jmp_req,
  input  logic [ADDR_W-1:0]  jmp_addr,
  output logic               halted
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic              inflight;       // read issued last cycle, data arriving now
  logic [ADDR_W-1:0] inflight_addr;  // address of that read
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              pop;
  logic              push;
  logic              jump;
  logic              wrap_gate;
  logic              issue;
  logic [ADDR_W+INSTR_W-1:0] buf_dout;

  // A jump outside IDLE beats everything else in the same cycle.
  assign jump      = !rst && jmp_req && (state != IDLE);
  // The wrap flag blocks issue combinationally so address 0 is never read.
  assign wrap_gate = HALT_ON_WRAP && pc_max_reached;
  assign pop       = ins_valid && ins_ready;

  // Slots committed after this cycle's pop; a new read may only be issued
  // if its data is guaranteed a buffer slot when it lands.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = !rst && (state == FETCH) && !jump && !wrap_gate
                 && (occ < 3'(FETCH_BUF_DEPTH));

  // A jump squashes the read landing this cycle.
  assign push  = inflight && !jump;

  always_comb begin
    state_nxt    = state;
    pc_inc       = 1'b0;
    pc_overwrite = 1'b0;
    pc_new_val   = '0;
    imem_en      = 1'b0;
    imem_addr    = '0;

    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (jump) state_nxt = FETCH;
               else if (wrap_gate) state_nxt = HALT;
      HALT:    if (jump) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase

    if (jump) begin
      pc_overwrite = 1'b1;
      pc_new_val   = jmp_addr;
    end
    if (issue) begin
      pc_inc    = 1'b1;
      imem_en   = 1'b1;
      imem_addr = pc_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) inflight_addr <= pc_val;
    end
  end

  fetch_skid_fifo #(
    .W(ADDR_W + INSTR_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({inflight_addr, imem_rdata}),
    .pop   (pop),
    .flush (jump),
    .dout  (buf_dout),
    .count (count)
  );

  assign ins_valid = (count != 2'd0);
  assign ins_addr  = buf_dout[ADDR_W+INSTR_W-1:INSTR_W];
  assign ins_data  = buf_dout[INSTR_W-1:0];
  assign halted    = (state == HALT) && (count == 2'd0) && !inflight;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int AW = 5;
  localparam int IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus drives two instances: [0] halts on wrap, [1] keeps fetching.
  logic          rst, start, ins_ready, jmp_req;
  logic [AW-1:0] jmp_addr;

  logic [1:0]    pc_inc, pc_overwrite, imem_en, ins_valid, halted, pc_max_reached;
  logic [AW-1:0] pc_new_val [2];
  logic [AW-1:0] imem_addr  [2];
  logic [AW-1:0] ins_addr   [2];
  logic [AW-1:0] pc_val     [2];
  logic [IW-1:0] ins_data   [2];
  logic [IW-1:0] imem_rdata [2];
  logic [IW-1:0] mem [32];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fetch_sequencer #(
      .ADDR_W(AW), .INSTR_W(IW), .HALT_ON_WRAP(g == 0)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .pc_val(pc_val[g]), .pc_max_reached(pc_max_reached[g]),
      .pc_inc(pc_inc[g]), .pc_overwrite(pc_overwrite[g]), .pc_new_val(pc_new_val[g]),
      .imem_en(imem_en[g]), .imem_addr(imem_addr[g]), .imem_rdata(imem_rdata[g]),
      .ins_valid(ins_valid[g]), .ins_ready(ins_ready),
      .ins_data(ins_data[g]), .ins_addr(ins_addr[g]),
      .jmp_req(jmp_req), .jmp_addr(jmp_addr), .halted(halted[g])
    );
  end

  // PC register and synchronous program memory models.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      imem_rdata[g] <= imem_en[g] ? mem[imem_addr[g]] : IW'($urandom);
      if (rst) begin
        pc_val[g] <= '0;
        pc_max_reached[g] <= 1'b0;
      end else if (pc_overwrite[g]) begin
        pc_val[g] <= pc_new_val[g];
        pc_max_reached[g] <= 1'b0;
      end else if (pc_inc[g]) begin
        pc_val[g] <= pc_val[g] + 1'b1;
        pc_max_reached[g] <= (pc_val[g] == '1);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Reference stream: after a start or jump the decoder must see consecutive
  // addresses from the new PC; the halting instance stops after address 31.
  int  q0[$];
  int  q1[$];
  bit  active;
  bit  prev_hold [2];
  logic [AW-1:0] prev_addr [2];
  logic [IW-1:0] prev_data [2];

  task automatic refill(input int a0, input int a1);
    q0.delete();
    q1.delete();
    for (int a = a0; a < 32; a++) q0.push_back(a);
    for (int i = 0; i < 200; i++) q1.push_back((a1 + i) % 32);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst) begin
        chk("inc_and_overwrite", pc_inc[g] & pc_overwrite[g], 0);
        chk("imem_en_eq_pc_inc", imem_en[g], pc_inc[g]);
        if (imem_en[g]) chk("imem_addr_eq_pc", imem_addr[g], pc_val[g]);
        if (g == 0 && pc_max_reached[0] && !jmp_req) chk("issue_after_wrap", imem_en[0], 0);
        if (prev_hold[g]) begin
          chk("hold_valid", ins_valid[g], 1);
          chk("hold_addr", ins_addr[g], prev_addr[g]);
          chk("hold_data", ins_data[g], prev_data[g]);
        end
        if (ins_valid[g] && ins_ready) begin
          int n;
          int e;
          n = (g == 0) ? q0.size() : q1.size();
          chk(g == 0 ? "sb_expected0" : "sb_expected1", n > 0, 1);
          if (n > 0) begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            chk(g == 0 ? "sb_addr0" : "sb_addr1", ins_addr[g], e);
            chk(g == 0 ? "sb_data0" : "sb_data1", ins_data[g], mem[e]);
          end
        end
      end
      prev_hold[g] = !rst && ins_valid[g] && !ins_ready && !(jmp_req && active);
      prev_addr[g] = ins_addr[g];
      prev_data[g] = ins_data[g];
    end
    if (rst) begin
      q0.delete();
      q1.delete();
      active = 1'b0;
    end else if (!active && start) begin
      active = 1'b1;
      refill(int'(pc_val[0]), int'(pc_val[1]));
    end else if (active && jmp_req) begin
      refill(int'(jmp_addr), int'(jmp_addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    for (int g = 0; g < 2; g++)
      chk(name, {pc_inc[g], pc_overwrite[g], pc_new_val[g], imem_en[g], imem_addr[g],
                 ins_valid[g], ins_data[g], ins_addr[g], halted[g]}, 0);
  endtask

  task automatic wait_pop0(input string name, input int req);
    bit got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (ins_valid[0] && ins_ready) got = 1'b1;
      else step();
    end
    chk({name, "_seen"}, got, 1);
    if (got) chk(name, ins_addr[0], req);
  endtask

  task automatic jump_to(input int a);
    step();
    jmp_req = 1'b1;
    jmp_addr = AW'(a);
    @(negedge clk);
    step();
    jmp_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pc_hold;
    int last0;
    int pops1;
    int zero_issue;
    bit prev_jmp;
    bit found;

    rst = 1'b1; start = 1'b0; ins_ready = 1'b0; jmp_req = 1'b0; jmp_addr = '0;
    for (int i = 0; i < 32; i++) mem[i] = IW'($urandom);
    repeat (3) step();
    @(negedge clk);
    check_zero("reset_outputs");
    step();
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle_outputs");

    // 1: stream from PC 0; first issue the cycle after start, valid 2 later.
    step(); ins_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("first_issue", imem_en[g], 1);
      chk("first_issue_addr", imem_addr[g], 0);
    end
    step(); @(negedge clk);
    chk("valid_early", ins_valid[0], 0);
    step(); @(negedge clk);
    chk("first_valid", ins_valid[0], 1);
    chk("first_addr", ins_addr[0], 0);
    for (int c = 0; c < 10; c++) begin
      step(); @(negedge clk);
      chk("throughput0", ins_valid[0], 1);
      chk("throughput1", ins_valid[1], 1);
    end

    // 2: backpressure for 5 cycles.
    step(); ins_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_no_issue", imem_en[0], 0);
      chk("stall_valid", ins_valid[0], 1);
      if (c == 1) pc_hold = pc_val[0];
      if (c == 4) chk("stall_pc_stable", pc_val[0], pc_hold);
      step();
    end
    ins_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("release_valid", ins_valid[0], 1);
      step();
    end

    // Randomized traffic with occasional jumps.
    prev_jmp = 1'b0;
    for (int c = 0; c < 120; c++) begin
      ins_ready = ($urandom_range(0, 3) != 0);
      jmp_req = !prev_jmp && ($urandom_range(0, 9) == 0);
      jmp_addr = AW'($urandom_range(0, 31));
      prev_jmp = jmp_req;
      step();
    end
    jmp_req = 1'b0;
    ins_ready = 1'b1;

    // 3: jump to 0x14 while address 7's read is in flight.
    jump_to(4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_en[0] && imem_addr[0] == 7) found = 1'b1;
      else step();
    end
    chk("saw_issue_7", found, 1);
    step();
    jmp_req = 1'b1; jmp_addr = 5'h14;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("jmp_overwrite", pc_overwrite[g], 1);
      chk("jmp_new_val", pc_new_val[g], 'h14);
      chk("jmp_no_inc", pc_inc[g], 0);
      chk("jmp_no_read", imem_en[g], 0);
    end
    step(); jmp_req = 1'b0;
    wait_pop0("after_jmp_addr", 'h14);

    // 4/5: run across the wrap; [0] halts after 31, [1] continues at 0.
    jump_to(25);
    last0 = -1; pops1 = 0; zero_issue = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ins_valid[0] && ins_ready) last0 = ins_addr[0];
      if (imem_en[0] && imem_addr[0] == 0) zero_issue++;
      if (c >= 3 && c <= 14 && ins_valid[1]) pops1++;
      step();
    end
    @(negedge clk);
    chk("last_before_halt", last0, 31);
    chk("addr0_never_issued", zero_issue, 0);
    chk("halted", halted[0], 1);
    chk("nohalt_no_halt", halted[1], 0);
    chk("wrap_no_gap", pops1, 12);
    step();
    jmp_req = 1'b1; jmp_addr = 5'd3;
    @(negedge clk);
    chk("halted_in_jmp_cycle", halted[0], 1);
    step(); jmp_req = 1'b0;
    @(negedge clk);
    chk("halted_clears", halted[0], 0);
    wait_pop0("resume_addr", 3);

    // 6: reset with a full buffer.
    step(); ins_ready = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("full_before_rst", ins_valid[0], 1);
    step(); rst = 1'b1;
    step(); rst = 1'b0; ins_ready = 1'b1;
    @(negedge clk);
    check_zero("mid_fetch_reset");
    for (int c = 0; c < 5; c++) begin
      step(); @(negedge clk);
      chk("idle_no_word", ins_valid[0] | ins_valid[1], 0);
      chk("idle_no_read", imem_en[0] | imem_en[1], 0);
    end
    step(); start = 1'b1;
    step(); start = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("restart_stream", ins_valid[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
